// File: rtl/rv32v_lane_mem_pkg.sv
// Shared types and helpers for the lane memory sequencer: element-width
// encoding, sequencer state, byte-enable generation and alignment check.
package rv32v_lane_mem_pkg;

   typedef enum logic [1:0] {
      EEW8     = 2'd0,
      EEW16    = 2'd1,
      EEW32    = 2'd2,
      EEW_RSVD = 2'd3
   } eew_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } lane_seq_state_t;

   // Byte enables for one element placed at byte offset off inside a word.
   function automatic logic [3:0] byte_ena_f(input eew_t eew, input logic [1:0] off);
      logic [3:0] be;
      case (eew)
         EEW8:    be = 4'b0001 << off;
         EEW16:   be = 4'b0011 << off;
         EEW32:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Natural alignment check; bytes are always aligned.
   function automatic logic misaligned_f(input eew_t eew, input logic [1:0] off);
      logic mis;
      case (eew)
         EEW16:   mis = off[0];
         EEW32:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/rv32v_lane_mem_sequencer_align.sv
// Combinational lane aligner: byte enables, store word shifted to its byte
// lane, and load element extracted and zero-extended from the cache word.
module rv32v_lane_align
   import rv32v_lane_mem_pkg::*;
(
   input  eew_t        eew,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] dmem_load,
   output logic [3:0]  byte_ena,
   output logic [31:0] store_word,
   output logic [31:0] load_elem
);

   logic [31:0] load_shifted;

   // Shift data to/from the addressed byte lane and mask loads to eew.
   always_comb begin
      byte_ena     = byte_ena_f(eew, off);
      store_word   = wdata << {off, 3'b000};
      load_shifted = dmem_load >> {off, 3'b000};
      case (eew)
         EEW8:    load_elem = {24'd0, load_shifted[7:0]};
         EEW16:   load_elem = {16'd0, load_shifted[15:0]};
         default: load_elem = load_shifted;
      endcase
   end

endmodule

// File: rtl/rv32v_lane_mem_sequencer.sv
// Vector lane memory sequencer: accepts one LANES-wide request, serialises
// the enabled lanes onto the single dcache port and returns collected load
// data. Optional macro RV32V_LANE_COALESCE_EN lets one load hit also fill
// later aligned lanes that share the same word address.
module rv32v_lane_mem_sequencer
   import rv32v_lane_mem_pkg::*;
#(
   parameter  int LANES      = 4,
   parameter  int ADDR_W     = 32,
   localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     flush,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_load,
   input  logic                     req_store,
   input  logic [1:0]               req_eew,
   input  logic [LANES-1:0]         req_lane_en,
   input  logic [LANES*ADDR_W-1:0]  req_addr,
   input  logic [LANES*32-1:0]      req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [LANES*32-1:0]      rsp_rdata,
   output logic                     rsp_exception,
   output logic [LANE_IDX_W-1:0]    rsp_exc_lane,
   output logic                     dmem_ren,
   output logic                     dmem_wen,
   output logic [ADDR_W-1:0]        dmem_addr,
   output logic [31:0]              dmem_store,
   output logic [3:0]               dmem_byte_ena,
   input  logic [31:0]              dmem_load,
   input  logic                     dmem_hit
);

   lane_seq_state_t state_q, state_d;

   logic                  load_q, load_d;
   logic                  store_q, store_d;
   eew_t                  eew_q, eew_d;
   logic [LANES-1:0]      pend_q, pend_d;
   logic [ADDR_W-1:0]     addr_q [LANES];
   logic [ADDR_W-1:0]     addr_d [LANES];
   logic [31:0]           wdata_q [LANES];
   logic [31:0]           wdata_d [LANES];
   logic [31:0]           rdata_q [LANES];
   logic [31:0]           rdata_d [LANES];
   logic                  exc_q, exc_d;
   logic [LANE_IDX_W-1:0] exc_lane_q, exc_lane_d;

   logic [LANE_IDX_W-1:0] ptr;
   logic [ADDR_W-1:0]     addr_p;
   logic                  mis_p;
   logic                  strobe;
   logic                  accept_to_done;
`ifdef RV32V_LANE_COALESCE_EN
   logic                  coal_stop;
`endif

   logic [3:0]  be_l [LANES];
   logic [31:0] st_l [LANES];
   logic [31:0] ld_l [LANES];

   for (genvar g = 0; g < LANES; g++) begin : g_align
      rv32v_lane_align u_align (
         .eew        (eew_q),
         .off        (addr_q[g][1:0]),
         .wdata      (wdata_q[g]),
         .dmem_load  (dmem_load),
         .byte_ena   (be_l[g]),
         .store_word (st_l[g]),
         .load_elem  (ld_l[g])
      );
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (req_valid) state_d = accept_to_done ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (mis_p || (dmem_hit && (pend_d == '0))) state_d = ST_DONE;
            ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Current lane is the lowest still-pending lane, so disabled lanes cost nothing.
   always_comb begin
      ptr = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (pend_q[i]) ptr = LANE_IDX_W'(i);
      end
      addr_p = addr_q[ptr];
      mis_p  = (state_q == ST_ISSUE) && misaligned_f(eew_q, addr_p[1:0]);
      strobe = (state_q == ST_ISSUE) && !mis_p;
   end

   // Request latch, lane retirement and load-data capture.
   always_comb begin
      load_d         = load_q;
      store_d        = store_q;
      eew_d          = eew_q;
      pend_d         = pend_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rdata_d        = rdata_q;
      exc_d          = exc_q;
      exc_lane_d     = exc_lane_q;
      accept_to_done = 1'b0;
`ifdef RV32V_LANE_COALESCE_EN
      coal_stop      = 1'b0;
`endif
      if (!flush) begin
         if (state_q == ST_IDLE && req_valid) begin
            load_d     = req_load;
            store_d    = req_store;
            eew_d      = eew_t'(req_eew);
            exc_d      = (req_eew == 2'd3) || (req_load && req_store);
            exc_lane_d = '0;
            for (int i = 0; i < LANES; i++) begin
               addr_d[i]  = req_addr[i*ADDR_W +: ADDR_W];
               wdata_d[i] = req_wdata[i*32 +: 32];
               rdata_d[i] = '0;
            end
            // Illegal or empty requests retire with no dcache traffic.
            if (exc_d || !(req_load || req_store)) pend_d = '0;
            else                                   pend_d = req_lane_en;
            accept_to_done = (pend_d == '0);
         end else if (state_q == ST_ISSUE) begin
            if (mis_p) begin
               exc_d      = 1'b1;
               exc_lane_d = ptr;
               pend_d     = '0;
            end else if (dmem_hit) begin
               if (load_q) rdata_d[ptr] = ld_l[ptr];
               pend_d[ptr] = 1'b0;
`ifdef RV32V_LANE_COALESCE_EN
               // Later aligned lanes in the same word share this read, up to
               // the first misaligned lane which must still raise its fault.
               if (load_q) begin
                  for (int j = 0; j < LANES; j++) begin
                     if (LANE_IDX_W'(j) > ptr && pend_q[j] && !coal_stop) begin
                        if (misaligned_f(eew_q, addr_q[j][1:0])) begin
                           coal_stop = 1'b1;
                        end else if (addr_q[j][ADDR_W-1:2] == addr_p[ADDR_W-1:2]) begin
                           rdata_d[j] = ld_l[j];
                           pend_d[j]  = 1'b0;
                        end
                     end
                  end
               end
`endif
            end
         end
      end
   end

   // Datapath registers; reset clears every buffer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         load_q     <= 1'b0;
         store_q    <= 1'b0;
         eew_q      <= EEW8;
         pend_q     <= '0;
         exc_q      <= 1'b0;
         exc_lane_q <= '0;
         for (int i = 0; i < LANES; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            rdata_q[i] <= '0;
         end
      end else begin
         load_q     <= load_d;
         store_q    <= store_d;
         eew_q      <= eew_d;
         pend_q     <= pend_d;
         exc_q      <= exc_d;
         exc_lane_q <= exc_lane_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   // Handshake and dcache outputs, all derived from registered state.
   always_comb begin
      req_ready     = (state_q == ST_IDLE);
      rsp_valid     = (state_q == ST_DONE);
      rsp_exception = exc_q;
      rsp_exc_lane  = exc_lane_q;
      for (int i = 0; i < LANES; i++) rsp_rdata[i*32 +: 32] = rdata_q[i];
      dmem_ren      = strobe && load_q;
      dmem_wen      = strobe && store_q;
      dmem_addr     = strobe ? {addr_p[ADDR_W-1:2], 2'b00} : '0;
      dmem_store    = strobe ? st_l[ptr] : '0;
      dmem_byte_ena = strobe ? be_l[ptr] : 4'b0000;
   end

endmodule
